// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer for the FFT datapath.
// Collects N ADC samples into the fft block, waits for the transform,
// kicks the SPI result transfer and waits for it to drain. Supports
// continuous (run) and one-shot (single) operation, a watchdog on both
// wait phases and a completed-frame counter.
module fft_frame_ctrl #(
    parameter int N       = 8,
    parameter int MSB     = 16,
    parameter int TIMEOUT = 4095
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 single,
    input  logic                 sample_valid,
    input  logic [MSB-1:0]       sample_in,
    output logic                 fft_insert,
    output logic [$clog2(N)-1:0] fft_addr,
    output logic [MSB-1:0]       fft_data,
    input  logic                 fft_finish,
    output logic                 spi_start,
    input  logic                 spi_done,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [7:0]           frame_cnt
);

    localparam int AW = $clog2(N);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_FFT,
        SEND,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   idx;
    logic [WW-1:0]   wcnt;

    logic            start;
    logic            accept;
    logic            frame_done;
    logic            timeout_hit;
    logic            wd_expired;

    // Write-port stage registers; vld_p1 is the insert strobe travelling with addr/data
    logic            vld_p1;
    logic [AW-1:0]   addr_p1;
    logic [MSB-1:0]  data_p1;

    // Watchdog counter increment that sticks at all-ones instead of wrapping
    function automatic logic [WW-1:0] sat_inc(input logic [WW-1:0] v);
        logic [WW-1:0] r;
        if (v == {WW{1'b1}}) begin
            r = v;
        end else begin
            r = v + WW'(1);
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-cycle event flags
    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        accept      = 1'b0;
        frame_done  = 1'b0;
        timeout_hit = 1'b0;
        wd_expired  = (wcnt == WW'(TIMEOUT));
        case (state)
            IDLE: begin
                // run and single together still mean a single start
                if (run || single) begin
                    start     = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (sample_valid) begin
                    accept = 1'b1;
                    if (idx == AW'(N - 1)) begin
                        state_nxt = WAIT_FFT;
                    end
                end
            end
            WAIT_FFT: begin
                // a finish arriving on the expiry cycle still counts
                if (fft_finish) begin
                    state_nxt = SEND;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            SEND: begin
                state_nxt = DRAIN;
            end
            DRAIN: begin
                if (spi_done) begin
                    frame_done = 1'b1;
                    state_nxt  = run ? LOAD : IDLE;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sample index: cleared at frame start, wraps to 0 after the last sample
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (start) begin
            idx <= '0;
        end else if (accept) begin
            idx <= idx + AW'(1);
        end
    end

    // Watchdog: restarts on every state change, counts while waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= '0;
        end else if (state_nxt != state) begin
            wcnt <= '0;
        end else if (state == WAIT_FFT || state == DRAIN) begin
            wcnt <= sat_inc(wcnt);
        end
    end

    // ---- stage p1: registered write port into the fft block ----
    // Address/data hold their last value between strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                addr_p1 <= idx;
                data_p1 <= sample_in;
            end
        end
    end

    // Registered status/handshake outputs, derived from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            spi_start   <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            spi_start <= (state_nxt == SEND);
            busy      <= (state_nxt != IDLE);
            if (start) begin
                err_timeout <= 1'b0;
            end else if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
            if (frame_done) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    assign fft_insert = vld_p1;
    assign fft_addr   = addr_p1;
    assign fft_data   = data_p1;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl. Two instances share the inputs:
// "dut" with the default watchdog and "dut_wd" with TIMEOUT=15 for the
// watchdog and expiry-cycle cases.
module tb_fft_frame_ctrl;

    logic        clk;
    logic        rst;
    logic        run;
    logic        single;
    logic        sample_valid;
    logic [15:0] sample_in;
    logic        fft_finish;
    logic        spi_done;

    logic        a_insert, a_spi_start, a_busy, a_err;
    logic [2:0]  a_addr;
    logic [15:0] a_data;
    logic [7:0]  a_cnt;

    logic        b_insert, b_spi_start, b_busy, b_err;
    logic [2:0]  b_addr;
    logic [15:0] b_data;
    logic [7:0]  b_cnt;

    int errors = 0;
    int checks = 0;
    logic seen;

    fft_frame_ctrl #(.N(8), .MSB(16), .TIMEOUT(4095)) dut (
        .clk(clk), .rst(rst), .run(run), .single(single),
        .sample_valid(sample_valid), .sample_in(sample_in),
        .fft_insert(a_insert), .fft_addr(a_addr), .fft_data(a_data),
        .fft_finish(fft_finish), .spi_start(a_spi_start), .spi_done(spi_done),
        .busy(a_busy), .err_timeout(a_err), .frame_cnt(a_cnt)
    );

    fft_frame_ctrl #(.N(8), .MSB(16), .TIMEOUT(15)) dut_wd (
        .clk(clk), .rst(rst), .run(run), .single(single),
        .sample_valid(sample_valid), .sample_in(sample_in),
        .fft_insert(b_insert), .fft_addr(b_addr), .fft_data(b_data),
        .fft_finish(fft_finish), .spi_start(b_spi_start), .spi_done(spi_done),
        .busy(b_busy), .err_timeout(b_err), .frame_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL tb_timeout: observed=no_finish expected=finish");
        $fatal(1, "bench time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, "_insert"}, a_insert, 0);
        chk({tag, "_addr"}, a_addr, 0);
        chk({tag, "_data"}, a_data, 0);
        chk({tag, "_spi_start"}, a_spi_start, 0);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_err"}, a_err, 0);
        chk({tag, "_frame_cnt"}, a_cnt, 0);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; single = 1'b0; sample_valid = 1'b0;
        sample_in = 16'h0; fft_finish = 1'b0; spi_done = 1'b0;
        tick();
        tick();
        chk_a_reset("reset");
        rst = 1'b0;
        tick();

        // Single frame, continuous samples
        single = 1'b1;
        tick();
        single = 1'b0;
        chk("t1_busy_after_start", a_busy, 1);
        for (int i = 0; i < 8; i++) begin
            sample_valid = 1'b1;
            sample_in = 16'((i + 1) * 256);
            tick();
            chk("t1_insert", a_insert, 1);
            chk("t1_addr", a_addr, i);
            chk("t1_data", a_data, (i + 1) * 256);
        end
        sample_valid = 1'b0;
        tick();
        chk("t1_insert_after_load", a_insert, 0);
        chk("t1_busy_wait_fft", a_busy, 1);
        fft_finish = 1'b1;
        tick();
        fft_finish = 1'b0;
        chk("t1_spi_start", a_spi_start, 1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | a_spi_start;
        end
        chk("t1_spi_start_single_pulse", seen, 0);
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        chk("t1_frame_cnt", a_cnt, 1);
        chk("t1_busy_end", a_busy, 0);

        // Gapped samples, stray strobes in WAIT_FFT
        single = 1'b1;
        tick();
        single = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sample_valid = 1'b1;
            sample_in = 16'hA000 + 16'(i);
            tick();
            sample_valid = 1'b0;
            chk("t2_insert", a_insert, 1);
            chk("t2_addr", a_addr, i);
            chk("t2_data", a_data, 32'hA000 + i);
            tick();
            chk("t2_gap_insert", a_insert, 0);
            chk("t2_gap_addr_hold", a_addr, i);
            tick();
            chk("t2_gap2_insert", a_insert, 0);
        end
        sample_valid = 1'b1;
        sample_in = 16'hFFFF;
        tick();
        sample_valid = 1'b0;
        chk("t2_stray_insert", a_insert, 0);
        chk("t2_stray_data_hold", a_data, 16'hA007);
        tick();
        chk("t2_stray_insert2", a_insert, 0);
        fft_finish = 1'b1;
        tick();
        fft_finish = 1'b0;
        chk("t2_spi_start", a_spi_start, 1);
        tick();
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        chk("t2_frame_cnt", a_cnt, 2);
        chk("t2_busy_end", a_busy, 0);

        // Continuous run, three frames, run dropped in the third
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t3_cnt_after_reset", a_cnt, 0);
        run = 1'b1;
        tick();
        chk("t3_busy_start", a_busy, 1);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) begin
                if (f == 2 && i == 4) run = 1'b0;
                sample_valid = 1'b1;
                sample_in = 16'(f * 256 + i);
                tick();
                chk("t3_insert", a_insert, 1);
                chk("t3_addr", a_addr, i);
            end
            sample_valid = 1'b0;
            repeat (3) tick();
            fft_finish = 1'b1;
            tick();
            fft_finish = 1'b0;
            chk("t3_spi_start", a_spi_start, 1);
            repeat (19) tick();
            spi_done = 1'b1;
            tick();
            spi_done = 1'b0;
            chk("t3_frame_cnt", a_cnt, f + 1);
            chk("t3_busy_after_frame", a_busy, (f < 2) ? 1 : 0);
        end
        repeat (3) tick();
        chk("t3_idle_busy", a_busy, 0);
        chk("t3_final_cnt", a_cnt, 3);

        // Watchdog on fft_finish (TIMEOUT=15 instance)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        single = 1'b1;
        tick();
        single = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sample_valid = 1'b1;
            sample_in = 16'h5000 + 16'(i);
            tick();
        end
        sample_valid = 1'b0;
        chk("t4_wd_in_wait", b_busy, 1);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen = seen | b_spi_start;
        end
        chk("t4_err_before_expiry", b_err, 0);
        chk("t4_busy_before_expiry", b_busy, 1);
        tick();
        seen = seen | b_spi_start;
        chk("t4_err_at_16", b_err, 1);
        chk("t4_busy_at_16", b_busy, 0);
        chk("t4_no_spi_start", seen, 0);
        chk("t4_cnt_unchanged", b_cnt, 0);
        tick();
        chk("t4_err_sticky", b_err, 1);
        single = 1'b1;
        tick();
        single = 1'b0;
        chk("t4_err_cleared", b_err, 0);
        chk("t4_busy_restart", b_busy, 1);

        // fft_finish on the expiry cycle, single during DRAIN
        for (int i = 0; i < 8; i++) begin
            sample_valid = 1'b1;
            sample_in = 16'h6000 + 16'(i);
            tick();
        end
        sample_valid = 1'b0;
        repeat (15) tick();
        fft_finish = 1'b1;
        tick();
        fft_finish = 1'b0;
        chk("t5_spi_start_on_expiry", b_spi_start, 1);
        chk("t5_err_on_expiry", b_err, 0);
        chk("t5_busy_on_expiry", b_busy, 1);
        tick();
        single = 1'b1;
        tick();
        single = 1'b0;
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        chk("t5_frame_cnt", b_cnt, 1);
        chk("t5_busy_end", b_busy, 0);
        tick();
        chk("t5_single_not_queued", b_busy, 0);

        // Mid-frame reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        single = 1'b1;
        tick();
        single = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample_valid = 1'b1;
            sample_in = 16'(32'h1111 * (i + 1));
            tick();
        end
        chk("t6_addr_before_rst", a_addr, 4);
        chk("t6_data_before_rst", a_data, 16'h5555);
        sample_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_a_reset("t6_rst");
        tick();
        single = 1'b1;
        tick();
        single = 1'b0;
        sample_valid = 1'b1;
        sample_in = 16'h7777;
        tick();
        sample_valid = 1'b0;
        chk("t6_restart_insert", a_insert, 1);
        chk("t6_restart_addr", a_addr, 0);
        chk("t6_restart_data", a_data, 16'h7777);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
